// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the store-side lane helpers.
package riscv_lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            LS_B:    store_be = 4'b0001 << off;
            LS_H:    store_be = 4'b0011 << off;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wd);
        case (funct3)
            LS_B:    store_data = {4{wd[7:0]}};
            LS_H:    store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword lane of a read word and extends it
// to 32 bits according to the load type.
module load_formatter
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'(rdata >> {addr, 3'b000});
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LS_B:    data = {{24{byte_lane[7]}}, byte_lane};
            LS_H:    data = {{16{half_lane[15]}}, half_lane};
            LS_W:    data = rdata;
            LS_BU:   data = {24'h0, byte_lane};
            LS_HU:   data = {16'h0, half_lane};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// M-stage load/store sequencer: checks the access, issues one data-memory
// request, waits for ack with a timeout and hands the formatted result on.
module load_store_unit
    import riscv_lsu_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        AccessFaultM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        buserr_q, buserr_d;

    logic        access, legal, aligned, valid;
    logic [31:0] fmt_data;

    load_formatter u_fmt (
        .rdata  (dmem_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (fmt_data)
    );

    // A store wins when both MemReadM and MemWriteM are set, so only the
    // unsigned sizes depend on the direction.
    always_comb begin
        access = MemReadM | MemWriteM;
        case (Funct3M)
            LS_B, LS_H, LS_W: legal = 1'b1;
            LS_BU, LS_HU:     legal = ~MemWriteM;
            default:          legal = 1'b0;
        endcase
        case (Funct3M[1:0])
            2'b01:   aligned = ~ALUResultM[0];
            2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        valid = access & legal & aligned;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        f3_d         = f3_q;
        rdata_d      = rdata_q;
        buserr_d     = buserr_q;
        StallM       = 1'b0;
        AccessFaultM = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    StallM   = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = 8'd0;
                    we_d     = MemWriteM;
                    addr_d   = ALUResultM;
                    wdata_d  = store_data(Funct3M, WriteDataM);
                    be_d     = store_be(Funct3M, ALUResultM[1:0]);
                    f3_d     = Funct3M;
                    rdata_d  = 32'h0;
                    buserr_d = 1'b0;
                end else begin
                    AccessFaultM = access;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (dmem_ack) begin
                    rdata_d  = we_q ? 32'h0 : fmt_data;
                    buserr_d = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    rdata_d  = 32'h0;
                    buserr_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            f3_q     <= 3'b000;
            rdata_q  <= 32'h0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            f3_q     <= f3_d;
            rdata_q  <= rdata_d;
            buserr_q <= buserr_d;
        end
    end

    assign dmem_req   = (state_q == BUSY);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign ReadDataM  = (state_q == DONE) ? rdata_q : 32'h0;
    assign BusErrM    = (state_q == DONE) & buserr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses
// plus hand sequences for timeout, ack/timeout priority and mid-BUSY reset.
module tb_load_store_unit;

    logic        clk, reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, AccessFaultM, BusErrM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.MAX_WAIT(16)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .StallM(StallM), .AccessFaultM(AccessFaultM), .BusErrM(BusErrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge with the FSM in IDLE; leaves it in IDLE.
    task automatic run_vec(input vec_t v);
        int stalls;
        stalls = 0;
        MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3;
        ALUResultM = v.addr; WriteDataM = v.wd; dmem_ack = 1'b0;
        #1;
        chk({v.name, " fault"}, 32'(AccessFaultM), 32'(v.exp_fault));
        if (v.exp_fault || !(v.rd || v.wr)) begin
            chk({v.name, " stall"}, 32'(StallM), 32'd0);
            step();
            chk({v.name, " no req"}, 32'(dmem_req), 32'd0);
            chk({v.name, " rdata0"}, ReadDataM, 32'h0);
            $display("%s: fault=%0b req=%0b", v.name, AccessFaultM, dmem_req);
        end else begin
            stalls += StallM;
            step();
            stalls += StallM;
            chk({v.name, " req"}, 32'(dmem_req), 32'd1);
            chk({v.name, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
            chk({v.name, " we"}, 32'(dmem_we), 32'(v.wr));
            if (v.wr) begin
                chk({v.name, " be"}, 32'(dmem_be), 32'(v.exp_be));
                chk({v.name, " wdata"}, dmem_wdata, v.exp_wdata);
            end
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            step();
            dmem_ack = 1'b0;
            stalls += StallM;
            chk({v.name, " result"}, ReadDataM, v.exp_rd);
            chk({v.name, " buserr"}, 32'(BusErrM), 32'd0);
            chk({v.name, " stall cycles"}, 32'(stalls), 32'd2);
            $display("%s: addr=0x%08h be=%b wdata=0x%08h rd=0x%08h stalls=%0d",
                     v.name, dmem_addr, dmem_be, dmem_wdata, ReadDataM, stalls);
            MemReadM = 1'b0; MemWriteM = 1'b0;
            step();
        end
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    initial begin
        int busy;
        vecs[0]  = '{"LB 0x103",   1, 0, 3'b000, 32'h103, 32'h0,        32'h80AA55CC, 0, 4'h0, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{"SH 0x202",   0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        0, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[2]  = '{"LW 0x301",   1, 0, 3'b010, 32'h301, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0};
        vecs[3]  = '{"LHU 0x402",  1, 0, 3'b101, 32'h402, 32'h0,        32'hF00DBEEF, 0, 4'h0, 32'h0,        32'h0000F00D};
        vecs[4]  = '{"LBU 0x405",  1, 0, 3'b100, 32'h405, 32'h0,        32'hF00DBEEF, 0, 4'h0, 32'h0,        32'h000000BE};
        vecs[5]  = '{"SB 0x001",   0, 1, 3'b000, 32'h001, 32'h000000A5, 32'h0,        0, 4'h2, 32'hA5A5A5A5, 32'h0};
        vecs[6]  = '{"SW 0x010",   0, 1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{"LH 0x006",   1, 0, 3'b001, 32'h006, 32'h0,        32'h80017FFF, 0, 4'h0, 32'h0,        32'hFFFF8001};
        vecs[8]  = '{"LH 0x001",   1, 0, 3'b001, 32'h001, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0};
        vecs[9]  = '{"SH 0x003",   0, 1, 3'b001, 32'h003, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0};
        vecs[10] = '{"S f3=100",   0, 1, 3'b100, 32'h000, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0};
        vecs[11] = '{"L f3=011",   1, 0, 3'b011, 32'h000, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0};
        vecs[12] = '{"RW SB 0x7",  1, 1, 3'b000, 32'h007, 32'h0000005A, 32'h11223344, 0, 4'h8, 32'h5A5A5A5A, 32'h0};
        vecs[13] = '{"LW 0x020",   1, 0, 3'b010, 32'h020, 32'h0,        32'h12345678, 0, 4'h0, 32'h0,        32'h12345678};
        vecs[14] = '{"no access",  0, 0, 3'b010, 32'h001, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0};

        reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
        #12;
        chk("reset req", 32'(dmem_req), 32'd0);
        chk("reset stall", 32'(StallM), 32'd0);
        chk("reset rdata", ReadDataM, 32'h0);
        chk("reset buserr", 32'(BusErrM), 32'd0);
        $display("reset: req=%0b stall=%0b rd=0x%08h", dmem_req, StallM, ReadDataM);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // LW with no ack: exactly 16 BUSY cycles then a one-cycle bus error.
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h40;
        step();
        busy = 0;
        for (int i = 0; i < 40 && dmem_req; i++) begin
            busy++;
            step();
        end
        chk("timeout busy cycles", 32'(busy), 32'd16);
        chk("timeout buserr", 32'(BusErrM), 32'd1);
        chk("timeout rdata", ReadDataM, 32'h0);
        chk("timeout stall", 32'(StallM), 32'd0);
        $display("timeout: busy=%0d buserr=%0b rd=0x%08h", busy, BusErrM, ReadDataM);
        MemReadM = 1'b0;
        step();
        chk("buserr pulse", 32'(BusErrM), 32'd0);

        // Ack arriving in the last allowed BUSY cycle beats the timeout.
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h44;
        step();
        repeat (15) step();
        chk("last busy req", 32'(dmem_req), 32'd1);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_ack = 1'b0;
        chk("ack wins rdata", ReadDataM, 32'hCAFEF00D);
        chk("ack wins buserr", 32'(BusErrM), 32'd0);
        $display("ack-vs-timeout: rd=0x%08h buserr=%0b", ReadDataM, BusErrM);
        MemReadM = 1'b0;
        step();

        // Reset in the third BUSY cycle, then a stray ack.
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h48;
        step(); step(); step();
        chk("busy3 req", 32'(dmem_req), 32'd1);
        reset = 1'b1; MemReadM = 1'b0;
        #1;
        chk("async reset req", 32'(dmem_req), 32'd0);
        chk("async reset stall", 32'(StallM), 32'd0);
        step();
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        step();
        dmem_ack = 1'b0;
        chk("late ack req", 32'(dmem_req), 32'd0);
        chk("late ack rdata", ReadDataM, 32'h0);
        chk("late ack buserr", 32'(BusErrM), 32'd0);
        step();
        chk("late ack rdata2", ReadDataM, 32'h0);
        $display("reset mid-busy: req=%0b rd=0x%08h", dmem_req, ReadDataM);
        run_vec(vecs[13]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MAX_WAIT, 16, cycles the unit waits for dmem_ack in BUSY before declaring a bus error (range 2..255).
REQ-002 clk  in  1  clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 MemReadM  in  1  M-stage instruction is a load.
REQ-005 MemWriteM  in  1  M-stage instruction is a store.
REQ-006 Funct3M  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResultM  in  32  byte address of the access.
REQ-008 WriteDataM  in  32  store data, right-aligned.
REQ-009 ReadDataM  out  32  formatted load result, consumed by the M/W pipeline register.
REQ-010 StallM  out  1  hold the F, D, E and M stages this cycle.
REQ-011 AccessFaultM  out  1  misaligned address or illegal Funct3M; the access is suppressed.
REQ-012 BusErrM  out  1  one-cycle pulse on ack timeout.
REQ-013 dmem_req  out  1  data-memory request.
REQ-014 dmem_we  out  1  write enable.
REQ-015 dmem_addr  out  32  word address {ALUResultM[31:2],2'b00}.
REQ-016 dmem_wdata  out  32  lane-replicated store data.
REQ-017 dmem_be  out  4  byte enables.
REQ-018 dmem_rdata  in  32  read word; valid in the cycle dmem_ack is high.
REQ-019 dmem_ack  in  1  request complete.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 A valid access is MemReadM|MemWriteM, with a legal Funct3M and an aligned address: H needs addr[0]=0; W needs addr[1:0]=0.
REQ-022 IDLE with a valid access: StallM=1 combinationally, and the FSM goes to BUSY next cycle.
REQ-023 IDLE with an invalid access: AccessFaultM=1 combinationally, StallM=0, no request issued, ReadDataM=0, the FSM stays in IDLE.
REQ-024 Legal store Funct3M values are 000, 001 and 010; legal load values are 000, 001, 010, 100 and 101.
REQ-025 If MemReadM and MemWriteM are both high, the access is treated as a store.
REQ-026 BUSY: dmem_req=1 and StallM=1; dmem_we, dmem_addr, dmem_wdata and dmem_be come from registers captured on IDLE->BUSY and stay stable until ack.
REQ-027 BUSY with dmem_ack=1: capture the formatted load data and go to DONE.
REQ-028 BUSY with the wait counter at MAX_WAIT-1 and no ack: go to DONE with BusErrM set and ReadDataM=0.
REQ-029 If ack and timeout occur in the same cycle, ack wins.
REQ-030 DONE: StallM=0, ReadDataM valid, BusErrM high only if a timeout occurred; the FSM returns unconditionally to IDLE.
REQ-031 Minimum latency is 3 cycles per access (IDLE, BUSY with ack, DONE), and back-to-back accesses are supported.
REQ-032 The wait counter clears on entry to BUSY and is 8 bits wide.
REQ-033 Store byte enables: B gives 4'b0001<<addr[1:0]; H gives 4'b0011<<addr[1:0]; W gives 4'b1111.
REQ-034 Store data: B replicates the byte ×4, H replicates the halfword ×2, W passes the word through.
REQ-035 Load extraction selects the byte or halfword lane by addr[1:0]; B and H sign-extend, BU and HU zero-extend, W passes the word through.
REQ-036 ReadDataM SHALL be 0 outside DONE and for stores.

Reset
REQ-037 On reset assertion, the FSM goes to IDLE; dmem_req, StallM, BusErrM, the counter, ReadDataM and all captured registers go to 0 immediately, including mid-BUSY.
REQ-038 After reset the unit ignores any late dmem_ack that arrives while it is in IDLE.

Structure
REQ-039 The package riscv_lsu_pkg SHALL hold the Funct3 size encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU) and the FSM state encoding.
REQ-040 A combinational sub-module, load_formatter, SHALL perform lane extraction and sign/zero extension (inputs rdata, addr[1:0], funct3); all sequencing stays in load_store_unit.

Verification
REQ-041 LB at addr 0x103, dmem_rdata 0x80AA55CC, ack in the first BUSY cycle -> ReadDataM=0xFFFFFF80 in DONE, StallM high for exactly 2 cycles.
REQ-042 SH at addr 0x202, WriteDataM 0x1234ABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200, dmem_we=1.
REQ-043 LW at addr 0x301 -> AccessFaultM=1, StallM=0, dmem_req never asserted.
REQ-044 LW with no ack and MAX_WAIT=16 -> 16 BUSY cycles, then DONE with BusErrM=1 for one cycle and ReadDataM=0.
REQ-045 Reset asserted in the 3rd BUSY cycle -> dmem_req=0 immediately; an ack one cycle later causes no state change.
REQ-046 LHU at 0x402 followed back-to-back by LBU at 0x405, rdata 0xF00DBEEF -> 0x0000F00D, then 0x000000BE, each with 3-cycle latency.
